cache_control_nway: RTL and testbench

CACHE_CONTROL_NWAY -- requirements
Module: cache_control_nway

---
 rtl/cache_types_pkg.sv | 17 +
 rtl/plru_tree.sv | 45 ++++
 rtl/cache_control_nway.sv | 179 +++++++++++++++++
 tb/tb_cache_control_nway.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cache_types_pkg.sv
// Shared types and constants for the N-way cache controller.
package cache_types_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FILL      = 2'd2
   } cache_state_e;

   // Largest supported associativity
   localparam int MAX_WAYS   = 8;

   // Cache line size in bytes (one byte-enable bit per byte)
   localparam int LINE_BYTES = 32;

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU helper: victim decode and hit update, purely combinational.
// Node 0 is the root, node n has children 2n+1 / 2n+2, a node bit of 0 points
// the victim into the lower half. Leaves (ways) sit after the WAYS-1 nodes.
module plru_tree #(
   parameter  int WAYS   = 4,
   localparam int LRU_W  = WAYS - 1,
   localparam int WSEL_W = $clog2(WAYS)
) (
   input  logic [LRU_W-1:0]  i_lru,
   input  logic [WSEL_W-1:0] i_way,
   output logic [WSEL_W-1:0] o_victim,
   output logic [LRU_W-1:0]  o_lru_upd
);

   // Victim walk: follow each node bit from the root down to a leaf
   always_comb begin : victim_walk
      int            node;
      logic [LRU_W-1:0] sh;
      node = 0;
      sh   = '0;
      for (int l = 0; l < WSEL_W; l++) begin
         sh   = i_lru >> node;
         node = 2 * node + 1 + int'(sh[0]);
      end
      o_victim = WSEL_W'(node - LRU_W);
   end

   // Hit update: every node on the accessed way's path points away from it
   always_comb begin : hit_update
      int                node;
      logic [WSEL_W-1:0] wsh;
      logic              dir;
      node      = 0;
      wsh       = '0;
      dir       = 1'b0;
      o_lru_upd = i_lru;
      for (int l = 0; l < WSEL_W; l++) begin
         wsh       = i_way >> (WSEL_W - 1 - l);
         dir       = wsh[0];
         o_lru_upd = (o_lru_upd & ~(LRU_W'(1) << node)) | (LRU_W'(!dir) << node);
         node      = 2 * node + 1 + int'(dir);
      end
   end

endmodule

// File: rtl/cache_control_nway.sv
// N-way set-associative cache controller: IDLE / WRITEBACK / FILL.
// Hits are answered combinationally in IDLE; a miss picks a victim (first
// invalid way, else tree-PLRU), optionally writes it back, refills it and
// returns to IDLE where the request is replayed as a hit.
// Optional build macro CACHE_CTRL_PERF_CNT_EN adds hit/miss/writeback counters.
module cache_control_nway
   import cache_types_pkg::*;
#(
   parameter  int WAYS   = 4,
   localparam int LRU_W  = WAYS - 1,
   localparam int WSEL_W = $clog2(WAYS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mem_read,
   input  logic                       mem_write,
   input  logic [LINE_BYTES-1:0]      mem_byte_enable256,
   input  logic [WAYS-1:0]            hit,
   input  logic [WAYS-1:0]            valid,
   input  logic [WAYS-1:0]            dirty,
   input  logic [LRU_W-1:0]           lru_out,
   input  logic                       pmem_resp,
   output logic                       mem_resp,
   output logic                       pmem_read,
   output logic                       pmem_write,
   output logic [WSEL_W-1:0]          way_sel,
   output logic [WAYS-1:0]            load_tag,
   output logic [WAYS-1:0]            load_valid,
   output logic [WAYS-1:0]            load_dirty,
   output logic                       valid_in,
   output logic                       dirty_in,
   output logic [WAYS*LINE_BYTES-1:0] data_we,
   output logic                       data_sel,
   output logic                       load_lru,
   output logic [LRU_W-1:0]           lru_in,
`ifdef CACHE_CTRL_PERF_CNT_EN
   output logic [31:0]                hit_count,
   output logic [31:0]                miss_count,
   output logic [31:0]                wb_count,
`endif
   output logic                       load_pmem_wdata
);

   cache_state_e      r_state;
   logic [WSEL_W-1:0] r_victim;

   logic              w_req;
   logic              w_any_hit;
   logic [WSEL_W-1:0] w_hit_way;
   logic              w_any_inv;
   logic [WSEL_W-1:0] w_inv_way;
   logic [WSEL_W-1:0] w_plru_way;
   logic [WSEL_W-1:0] w_victim;
   logic              w_vic_dirty;
   logic [LRU_W-1:0]  w_lru_upd;

`ifdef CACHE_CTRL_PERF_CNT_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;
   logic [31:0] r_wb_cnt;

   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;
   assign wb_count   = r_wb_cnt;
`endif

   assign w_req = mem_read | mem_write;

   // Lowest-index hit and lowest-index invalid way (scan high to low so low wins)
   always_comb begin
      w_any_hit = 1'b0;
      w_hit_way = '0;
      w_any_inv = 1'b0;
      w_inv_way = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (hit[i]) begin
            w_any_hit = 1'b1;
            w_hit_way = WSEL_W'(i);
         end
         if (!valid[i]) begin
            w_any_inv = 1'b1;
            w_inv_way = WSEL_W'(i);
         end
      end
   end

   plru_tree #(.WAYS(WAYS)) u_plru (
      .i_lru     (lru_out),
      .i_way     (w_hit_way),
      .o_victim  (w_plru_way),
      .o_lru_upd (w_lru_upd)
   );

   assign w_victim    = w_any_inv ? w_inv_way : w_plru_way;
   assign w_vic_dirty = valid[w_victim] & dirty[w_victim];

   // State, victim latch and counters; the victim only moves on an IDLE miss
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_victim <= '0;
`ifdef CACHE_CTRL_PERF_CNT_EN
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         r_wb_cnt   <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req && w_any_hit) begin
`ifdef CACHE_CTRL_PERF_CNT_EN
                  r_hit_cnt <= r_hit_cnt + 32'd1;
`endif
               end else if (w_req) begin
                  r_victim <= w_victim;
                  r_state  <= w_vic_dirty ? WRITEBACK : FILL;
`ifdef CACHE_CTRL_PERF_CNT_EN
                  r_miss_cnt <= r_miss_cnt + 32'd1;
                  if (w_vic_dirty) r_wb_cnt <= r_wb_cnt + 32'd1;
`endif
               end
            end
            WRITEBACK: if (pmem_resp) r_state <= FILL;
            FILL:      if (pmem_resp) r_state <= IDLE;
            default:   r_state <= IDLE;
         endcase
      end
   end

   // Array strobes and handshakes; combinational so a hit answers in one cycle
   always_comb begin
      mem_resp        = 1'b0;
      pmem_read       = 1'b0;
      pmem_write      = 1'b0;
      way_sel         = r_victim;
      load_tag        = '0;
      load_valid      = '0;
      load_dirty      = '0;
      valid_in        = 1'b0;
      dirty_in        = 1'b0;
      data_we         = '0;
      data_sel        = 1'b0;
      load_lru        = 1'b0;
      lru_in          = '0;
      load_pmem_wdata = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req && w_any_hit) begin
               mem_resp = 1'b1;
               load_lru = 1'b1;
               lru_in   = w_lru_upd;
               way_sel  = w_hit_way;
               if (mem_write) begin
                  data_sel                                    = 1'b1;
                  data_we[LINE_BYTES*int'(w_hit_way) +: LINE_BYTES] = mem_byte_enable256;
                  load_dirty[w_hit_way]                       = 1'b1;
                  dirty_in                                    = 1'b1;
               end
            end
         end
         WRITEBACK: begin
            pmem_write      = 1'b1;
            load_pmem_wdata = 1'b1;
            if (pmem_resp) load_dirty[r_victim] = 1'b1;
         end
         FILL: begin
            pmem_read = 1'b1;
            if (pmem_resp) begin
               data_we[LINE_BYTES*int'(r_victim) +: LINE_BYTES] = '1;
               load_tag[r_victim]   = 1'b1;
               load_valid[r_victim] = 1'b1;
               valid_in             = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_control_nway.sv
// Directed bench for cache_control_nway (WAYS=4).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_cache_control_nway;

   logic         clk = 1'b0;
   logic         rst;
   logic         mem_read, mem_write;
   logic [31:0]  mem_byte_enable256;
   logic [3:0]   hit, valid, dirty;
   logic [2:0]   lru_out;
   logic         pmem_resp;
   logic         mem_resp, pmem_read, pmem_write;
   logic [1:0]   way_sel;
   logic [3:0]   load_tag, load_valid, load_dirty;
   logic         valid_in, dirty_in;
   logic [127:0] data_we;
   logic         data_sel, load_lru;
   logic [2:0]   lru_in;
   logic         load_pmem_wdata;
`ifdef CACHE_CTRL_PERF_CNT_EN
   logic [31:0]  hit_count, miss_count, wb_count;
`endif

   int passed = 0;
   int total  = 0;

   cache_control_nway #(.WAYS(4)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_byte_enable256(mem_byte_enable256),
      .hit(hit), .valid(valid), .dirty(dirty), .lru_out(lru_out),
      .pmem_resp(pmem_resp),
      .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .way_sel(way_sel),
      .load_tag(load_tag), .load_valid(load_valid), .load_dirty(load_dirty),
      .valid_in(valid_in), .dirty_in(dirty_in),
      .data_we(data_we), .data_sel(data_sel),
      .load_lru(load_lru), .lru_in(lru_in),
`ifdef CACHE_CTRL_PERF_CNT_EN
      .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count),
`endif
      .load_pmem_wdata(load_pmem_wdata)
   );

   always #5 clk = ~clk;

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      mem_read = 0; mem_write = 0; mem_byte_enable256 = 0;
      hit = 0; valid = 4'hF; dirty = 0; lru_out = 0; pmem_resp = 0;
   endtask

   task automatic test_reset();
      rst = 0; idle_inputs();
      nxt(); nxt(); rst = 1; #1;
      total++; if (pmem_read !== 1'b0) $display("FAIL rst_pmem_read got=%0b exp=0", pmem_read); else passed++;
      total++; if (mem_resp !== 1'b0) $display("FAIL rst_mem_resp got=%0b exp=0", mem_resp); else passed++;
      // drive into FILL then abort it with reset
      nxt(); mem_read = 1; valid = 4'b0111; #1;
      nxt(); #1;
      total++; if (pmem_read !== 1'b1) $display("FAIL pre_abort_fill got=%0b exp=1", pmem_read); else passed++;
      rst = 0; mem_read = 0;
      nxt(); #1;
      total++; if (pmem_read !== 1'b0) $display("FAIL abort_pmem_read got=%0b exp=0", pmem_read); else passed++;
      nxt(); rst = 1; #1;
      total++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) $display("FAIL abort_pmem got=%0b%0b exp=00", pmem_read, pmem_write); else passed++;
      // IDLE answers a hit straight away
      mem_read = 1; hit = 4'b0001; valid = 4'hF; #1;
      total++; if (mem_resp !== 1'b1) $display("FAIL abort_idle_resp got=%0b exp=1", mem_resp); else passed++;
      nxt(); idle_inputs();
   endtask

   task automatic test_idle();
      idle_inputs(); hit = 4'b0101; #1;
      total++; if ({mem_resp, pmem_read, pmem_write, load_lru, load_pmem_wdata, data_sel} !== 6'b0)
         $display("FAIL idle_strobes got=%b exp=000000", {mem_resp, pmem_read, pmem_write, load_lru, load_pmem_wdata, data_sel}); else passed++;
      total++; if ({load_tag, load_valid, load_dirty} !== 12'h0 || data_we !== 128'h0)
         $display("FAIL idle_loads got=%h/%h exp=0/0", {load_tag, load_valid, load_dirty}, data_we); else passed++;
      nxt(); idle_inputs();
   endtask

   task automatic test_read_hit();
      mem_read = 1; hit = 4'b0100; lru_out = 3'b000; #1;
      total++; if (mem_resp !== 1'b1 || load_lru !== 1'b1) $display("FAIL rd_hit_resp got=%0b%0b exp=11", mem_resp, load_lru); else passed++;
      total++; if (way_sel !== 2'd2) $display("FAIL rd_hit_way got=%0d exp=2", way_sel); else passed++;
      total++; if (lru_in !== 3'b100) $display("FAIL rd_hit_lru2 got=%b exp=100", lru_in); else passed++;
      total++; if (data_we !== 128'h0 || load_dirty !== 4'b0) $display("FAIL rd_hit_nowrite got=%h/%b exp=0/0000", data_we, load_dirty); else passed++;
      nxt(); hit = 4'b0001; lru_out = 3'b000; #1;
      total++; if (lru_in !== 3'b011) $display("FAIL rd_hit_lru0 got=%b exp=011", lru_in); else passed++;
      nxt(); hit = 4'b1000; lru_out = 3'b111; #1;
      total++; if (lru_in !== 3'b010 || way_sel !== 2'd3) $display("FAIL rd_hit_lru3 got=%b/%0d exp=010/3", lru_in, way_sel); else passed++;
      // two hit bits: the lower way wins
      nxt(); hit = 4'b0110; lru_out = 3'b000; #1;
      total++; if (way_sel !== 2'd1 || lru_in !== 3'b001) $display("FAIL multi_hit got=%0d/%b exp=1/001", way_sel, lru_in); else passed++;
      nxt(); idle_inputs();
   endtask

   task automatic test_write_hit();
      mem_write = 1; hit = 4'b0010; mem_byte_enable256 = 32'h0000000F; #1;
      total++; if (data_we !== {64'h0, 32'h0000000F, 32'h0}) $display("FAIL wr_hit_we got=%h exp=%h", data_we, {64'h0, 32'h0000000F, 32'h0}); else passed++;
      total++; if (load_dirty !== 4'b0010 || dirty_in !== 1'b1) $display("FAIL wr_hit_dirty got=%b/%0b exp=0010/1", load_dirty, dirty_in); else passed++;
      total++; if (mem_resp !== 1'b1 || data_sel !== 1'b1) $display("FAIL wr_hit_resp got=%0b%0b exp=11", mem_resp, data_sel); else passed++;
      // read and write together: write wins
      nxt(); mem_read = 1; hit = 4'b1000; mem_byte_enable256 = 32'hA5A5_0001; #1;
      total++; if (data_we !== {32'hA5A5_0001, 96'h0} || load_dirty !== 4'b1000)
         $display("FAIL rw_priority got=%h/%b exp=%h/1000", data_we, load_dirty, {32'hA5A5_0001, 96'h0}); else passed++;
      nxt(); idle_inputs();
   endtask

   task automatic test_dirty_miss();
      mem_read = 1; valid = 4'hF; dirty = 4'b0001; lru_out = 3'b000; #1;
      total++; if (mem_resp !== 1'b0 || pmem_write !== 1'b0) $display("FAIL dmiss_idle got=%0b%0b exp=00", mem_resp, pmem_write); else passed++;
      nxt(); #1;
      total++; if (pmem_write !== 1'b1 || load_pmem_wdata !== 1'b1 || way_sel !== 2'd0)
         $display("FAIL wb_c1 got=%0b%0b/%0d exp=11/0", pmem_write, load_pmem_wdata, way_sel); else passed++;
      total++; if (load_dirty !== 4'b0) $display("FAIL wb_c1_dirty got=%b exp=0000", load_dirty); else passed++;
      nxt(); #1;
      total++; if (pmem_write !== 1'b1) $display("FAIL wb_c2 got=%0b exp=1", pmem_write); else passed++;
      nxt(); pmem_resp = 1; #1;
      total++; if (load_dirty !== 4'b0001 || dirty_in !== 1'b0) $display("FAIL wb_clean got=%b/%0b exp=0001/0", load_dirty, dirty_in); else passed++;
      nxt(); pmem_resp = 0; #1;
      total++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) $display("FAIL fill_c1 got=%0b%0b exp=10", pmem_read, pmem_write); else passed++;
      nxt(); pmem_resp = 1; #1;
      total++; if (load_tag !== 4'b0001 || load_valid !== 4'b0001 || valid_in !== 1'b1)
         $display("FAIL fill_load got=%b/%b/%0b exp=0001/0001/1", load_tag, load_valid, valid_in); else passed++;
      total++; if (data_we !== {96'h0, 32'hFFFFFFFF} || data_sel !== 1'b0) $display("FAIL fill_we got=%h/%0b exp=ffffffff/0", data_we, data_sel); else passed++;
      nxt(); pmem_resp = 0; hit = 4'b0001; dirty = 0; #1;
      total++; if (mem_resp !== 1'b1 || pmem_read !== 1'b0) $display("FAIL refill_hit got=%0b%0b exp=10", mem_resp, pmem_read); else passed++;
      nxt(); idle_inputs();
   endtask

   task automatic test_clean_miss();
      mem_read = 1; valid = 4'b1011; dirty = 4'b1111; lru_out = 3'b000; #1;
      nxt(); valid = 4'hF; lru_out = 3'b111; #1;
      total++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) $display("FAIL cmiss_fill got=%0b%0b exp=10", pmem_read, pmem_write); else passed++;
      total++; if (way_sel !== 2'd2) $display("FAIL cmiss_victim got=%0d exp=2", way_sel); else passed++;
      nxt(); pmem_resp = 1; #1;
      total++; if (load_tag !== 4'b0100 || data_we !== {32'h0, 32'hFFFFFFFF, 64'h0}) $display("FAIL cmiss_load got=%b/%h exp=0100", load_tag, data_we); else passed++;
      nxt(); idle_inputs();
      // all valid, PLRU 101 -> way 3
      mem_read = 1; valid = 4'hF; dirty = 4'b0001; lru_out = 3'b101; #1;
      nxt(); #1;
      total++; if (pmem_read !== 1'b1 || way_sel !== 2'd3) $display("FAIL plru_victim got=%0b/%0d exp=1/3", pmem_read, way_sel); else passed++;
      nxt(); pmem_resp = 1; #1;
      total++; if (load_tag !== 4'b1000) $display("FAIL plru_load got=%b exp=1000", load_tag); else passed++;
      nxt(); idle_inputs();
   endtask

`ifdef CACHE_CTRL_PERF_CNT_EN
   task automatic test_counters();
      rst = 0; nxt(); rst = 1;
      mem_read = 1; hit = 4'b0010;
      nxt(); nxt(); nxt();
      hit = 0; dirty = 4'b0001; lru_out = 3'b000;
      nxt(); pmem_resp = 1;          // WRITEBACK, completes immediately
      nxt();                         // FILL, completes immediately
      nxt(); pmem_resp = 0; hit = 4'b0001; dirty = 0;
      nxt(); idle_inputs(); #1;
      total++; if (hit_count !== 32'd4) $display("FAIL hit_count got=%0d exp=4", hit_count); else passed++;
      total++; if (miss_count !== 32'd1) $display("FAIL miss_count got=%0d exp=1", miss_count); else passed++;
      total++; if (wb_count !== 32'd1) $display("FAIL wb_count got=%0d exp=1", wb_count); else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_idle();
      test_read_hit();
      test_write_hit();
      test_dirty_miss();
      test_clean_miss();
`ifdef CACHE_CTRL_PERF_CNT_EN
      test_counters();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
